// File: rtl/frame_capture_buffer.sv
// Captures one IMG_W x IMG_H frame into on-chip RAM, then replays it on a valid/ready stream.
// Optional GREY_REPLAY_EN: replayed pixels become (R + 2G + B) >> 2 on all three bytes.
module frame_capture_buffer #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned DATA_W = 24
) (
    input  logic                       axi_clk,
    input  logic                       reset,
    input  logic                       i_rgb_data_valid,
    input  logic [DATA_W-1:0]          i_rgb_data,
    input  logic                       i_line_flag,
    output logic                       o_capture_ready,
    output logic [DATA_W-1:0]          o_rgb_data,
    output logic                       o_rgb_data_valid,
    input  logic                       i_rgb_data_ready,
    output logic [$clog2(IMG_W)-1:0]   o_x,
    output logic [$clog2(IMG_H)-1:0]   o_y,
    output logic                       o_frame_done,
    output logic                       o_overflow
);

    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);
    localparam int unsigned AW    = XW + YW;
    localparam int unsigned DEPTH = IMG_W * IMG_H;

    typedef enum logic {CAPTURE, REPLAY} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     tx_cnt;
    logic              rd_done;
    logic              ram_vld;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] pix_c;
    logic [DATA_W-1:0] skid;
    logic              skid_vld;

    logic       accept_c;
    logic       wr_en_c;
    logic       xfer_c;
    logic       last_xfer_c;
    logic       issue_c;
    logic [1:0] occ_c;

    assign accept_c    = i_rgb_data_valid && i_line_flag;
    assign wr_en_c     = accept_c && (state == CAPTURE);
    assign xfer_c      = o_rgb_data_valid && i_rgb_data_ready;
    assign last_xfer_c = xfer_c && (tx_cnt == '1);

    // Output reg + skid reg + one read in flight never exceed two pixels; only read when a slot frees.
    assign occ_c   = 2'(o_rgb_data_valid) + 2'(skid_vld) + 2'(ram_vld) - 2'(xfer_c);
    assign issue_c = (state == REPLAY) && !rd_done && (occ_c < 2'd2);

    always_ff @(posedge axi_clk) begin
        if (wr_en_c) mem[{o_y, o_x}] <= i_rgb_data;
        if (issue_c) ram_q <= mem[rd_addr];
    end

`ifdef GREY_REPLAY_EN
    logic [9:0] grey_sum_c;
    assign grey_sum_c = 10'(ram_q[23:16]) + 10'({ram_q[15:8], 1'b0}) + 10'(ram_q[7:0]);
    assign pix_c      = {3{grey_sum_c[9:2]}};
`else
    assign pix_c = ram_q;
`endif

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state            <= CAPTURE;
            o_capture_ready  <= 1'b1;
            o_x              <= '0;
            o_y              <= '0;
            rd_addr          <= '0;
            tx_cnt           <= '0;
            rd_done          <= 1'b0;
            ram_vld          <= 1'b0;
            skid             <= '0;
            skid_vld         <= 1'b0;
            o_rgb_data       <= '0;
            o_rgb_data_valid <= 1'b0;
            o_frame_done     <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            o_frame_done <= last_xfer_c;
            ram_vld      <= issue_c;
            if (accept_c && (state != CAPTURE)) o_overflow <= 1'b1;
            if (xfer_c) tx_cnt <= tx_cnt + AW'(1);
            if (issue_c) begin
                rd_addr <= rd_addr + AW'(1);
                if (rd_addr == '1) rd_done <= 1'b1;
            end

            // Refill the output from skid first, then from RAM; park RAM data in skid while stalled.
            if (!o_rgb_data_valid || xfer_c) begin
                if (skid_vld) begin
                    o_rgb_data       <= skid;
                    o_rgb_data_valid <= 1'b1;
                    skid_vld         <= ram_vld;
                    if (ram_vld) skid <= pix_c;
                end else if (ram_vld) begin
                    o_rgb_data       <= pix_c;
                    o_rgb_data_valid <= 1'b1;
                end else begin
                    o_rgb_data_valid <= 1'b0;
                end
            end else if (ram_vld) begin
                skid     <= pix_c;
                skid_vld <= 1'b1;
            end

            case (state)
                CAPTURE: begin
                    if (wr_en_c) begin
                        o_x <= o_x + XW'(1);
                        if (o_x == '1) begin
                            o_y <= o_y + YW'(1);
                            if (o_y == '1) begin
                                state           <= REPLAY;
                                o_capture_ready <= 1'b0;
                                rd_done         <= 1'b0;
                                rd_addr         <= '0;
                            end
                        end
                    end
                end
                REPLAY: begin
                    if (last_xfer_c) begin
                        state           <= CAPTURE;
                        o_capture_ready <= 1'b1;
                        rd_addr         <= '0;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Self-checking bench for frame_capture_buffer: vector table, directed sequences, random traffic vs. a queue model.
module tb_frame_capture_buffer;

    localparam int W = 64;
    localparam int H = 64;
    localparam int N = W * H;
`ifdef GREY_REPLAY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        v, f, r;
    logic [23:0] din;
    logic        o_capture_ready;
    logic [23:0] o_rgb_data;
    logic        o_rgb_data_valid;
    logic [5:0]  o_x;
    logic [5:0]  o_y;
    logic        o_frame_done;
    logic        o_overflow;

    frame_capture_buffer dut (
        .axi_clk          (clk),
        .reset            (reset),
        .i_rgb_data_valid (v),
        .i_rgb_data       (din),
        .i_line_flag      (f),
        .o_capture_ready  (o_capture_ready),
        .o_rgb_data       (o_rgb_data),
        .o_rgb_data_valid (o_rgb_data_valid),
        .i_rgb_data_ready (r),
        .o_x              (o_x),
        .o_y              (o_y),
        .o_frame_done     (o_frame_done),
        .o_overflow       (o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] exp_q[$];
    bit ovf_m;

    typedef struct {
        bit          v;
        bit          f;
        logic [23:0] d;
        int          ex;
        int          ey;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] model_out(input logic [23:0] p);
`ifdef GREY_REPLAY_EN
        int rr, gg, bb, s;
        logic [7:0] g8;
        rr = int'(p[23:16]);
        gg = int'(p[15:8]);
        bb = int'(p[7:0]);
        s  = (rr + 2 * gg + bb) / 4;
        g8 = 8'(s);
        return {g8, g8, g8};
`else
        return p;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; v = 1'b0; f = 1'b0; r = 1'b0; din = '0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic check_xy(input string tag);
        chk({tag, "_x"}, 32'(o_x), 32'(exp_q.size() % W));
        chk({tag, "_y"}, 32'(o_y), 32'((exp_q.size() / W) % H));
    endtask

    // mode 0: every cycle, data = index; 1: line_flag toggles, data = index; 2: random qualifiers/data
    task automatic capture(input int n, input int mode);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 20 * n + 100) begin
            case (mode)
                0: begin v = 1'b1; f = 1'b1; end
                1: begin v = 1'b1; f = cyc[0] == 1'b0; end
                default: begin v = $urandom_range(0, 3) != 0; f = $urandom_range(0, 3) != 0; end
            endcase
            din = (mode == 2) ? 24'($urandom) : ((v && f) ? 24'(exp_q.size()) : 24'hABCDEF);
            if (v && f) begin
                exp_q.push_back(din);
                acc++;
            end
            step();
            cyc++;
            if (mode == 1 && v && f && exp_q.size() == N / 2) begin
                chk("half_frame_x", 32'(o_x), 32'(0));
                chk("half_frame_y", 32'(o_y), 32'(H / 2));
            end
        end
        chk("capture_count", 32'(acc), 32'(n));
        v = 1'b0; f = 1'b0;
        if (exp_q.size() == N) chk("capture_ready_low", 32'(o_capture_ready), 32'(0));
        else check_xy("capture_end");
    endtask

    // rmode 0: ready high; 1: ready 1,0,0,1 pattern; 2: random. inject = junk pixels offered at start.
    task automatic drain(input int rmode, input int inject);
        int cyc = 0, got = 0, fd = 0, bubbles = 0, first = -1;
        int total = exp_q.size();
        bit held = 1'b0, done = 1'b0, seen = 1'b0;
        logic [23:0] hold_d, ev;
        while (!done && cyc < 40000) begin
            case (rmode)
                0: r = 1'b1;
                1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (inject > 0) begin
                v = 1'b1; f = 1'b1; din = 24'($urandom); inject--; ovf_m = 1'b1;
            end else begin
                v = 1'b0; f = 1'b0;
            end
            if (held) begin
                chk("stall_valid", 32'(o_rgb_data_valid), 32'(1));
                chk("stall_data", 32'(o_rgb_data), 32'(hold_d));
            end
            if (o_rgb_data_valid) begin
                if (!seen) first = cyc;
                seen = 1'b1;
            end else if (seen) bubbles++;
            if (o_rgb_data_valid && r) begin
                ev = (exp_q.size() > 0) ? model_out(exp_q.pop_front()) : 24'hxxxxxx;
                chk("replay_data", 32'(o_rgb_data), 32'(ev));
                got++;
                held = 1'b0;
            end else if (o_rgb_data_valid) begin
                held = 1'b1;
                hold_d = o_rgb_data;
            end else held = 1'b0;
            step();
            cyc++;
            if (o_frame_done) fd++;
            if (got == total) begin
                chk("frame_done_on_last", 32'(o_frame_done), 32'(1));
                chk("valid_low_after_last", 32'(o_rgb_data_valid), 32'(0));
                done = 1'b1;
            end
        end
        v = 1'b0; f = 1'b0;
        chk("replay_count", 32'(got), 32'(total));
        chk("first_valid_latency_ok", 32'(first >= 0 && first <= LAT), 32'(1));
        if (rmode == 0) chk("bubbles", 32'(bubbles), 32'(0));
        chk("frame_done_pulses", 32'(fd), 32'(1));
        chk("overflow", 32'(o_overflow), 32'(ovf_m));
        r = 1'b0;
        step();
        chk("frame_done_one_cycle", 32'(o_frame_done), 32'(0));
        chk("capture_ready_back", 32'(o_capture_ready), 32'(1));
        chk("overflow_sticky", 32'(o_overflow), 32'(ovf_m));
        check_xy("after_replay");
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b1, 1'b1, 24'h111111, 1, 0};
        vecs[1] = '{1'b1, 1'b0, 24'h222222, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 24'h333333, 1, 0};
        vecs[3] = '{1'b0, 1'b0, 24'h444444, 1, 0};
        vecs[4] = '{1'b1, 1'b1, 24'h555555, 2, 0};
        vecs[5] = '{1'b1, 1'b1, 24'h804020, 3, 0};
        vecs[6] = '{1'b0, 1'b1, 24'h777777, 3, 0};
        vecs[7] = '{1'b1, 1'b1, 24'hFFFFFF, 4, 0};

        do_reset();
        chk("rst_x", 32'(o_x), 32'(0));
        chk("rst_y", 32'(o_y), 32'(0));
        chk("rst_valid", 32'(o_rgb_data_valid), 32'(0));
        chk("rst_data", 32'(o_rgb_data), 32'(0));
        chk("rst_frame_done", 32'(o_frame_done), 32'(0));
        chk("rst_overflow", 32'(o_overflow), 32'(0));
        chk("rst_capture_ready", 32'(o_capture_ready), 32'(1));

        // Qualifier table: only valid && line_flag advances the write position.
        r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = vecs[i].v; f = vecs[i].f; din = vecs[i].d;
            if (vecs[i].v && vecs[i].f) exp_q.push_back(vecs[i].d);
            step();
            chk("vec_x", 32'(o_x), 32'(vecs[i].ex));
            chk("vec_y", 32'(o_y), 32'(vecs[i].ey));
            chk("vec_no_replay", 32'(o_rgb_data_valid), 32'(0));
        end
        v = 1'b0; f = 1'b0;
        capture(N - exp_q.size(), 2);
        drain(2, 0);

        capture(N, 0);
        drain(0, 0);

        capture(N, 1);
        drain(1, 0);

        capture(N, 2);
        drain(0, 5);

        // Reset mid-capture, then a full new frame.
        capture(1000, 2);
        do_reset();
        chk("midrst_x", 32'(o_x), 32'(0));
        chk("midrst_y", 32'(o_y), 32'(0));
        chk("midrst_overflow", 32'(o_overflow), 32'(0));
        capture(N, 2);
        drain(2, 0);

        // Reset mid-replay while stalled.
        capture(N, 0);
        r = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("stalled_valid", 32'(o_rgb_data_valid), 32'(1));
        do_reset();
        chk("replay_rst_valid", 32'(o_rgb_data_valid), 32'(0));
        chk("replay_rst_capture_ready", 32'(o_capture_ready), 32'(1));
        capture(N, 2);
        drain(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
